ctrl_debounce: RTL
==================

// Module: ctrl_debounce
// PURPOSE
//  Conditions two raw push-button inputs into the pause/restart controls of the
//  3-state sequencer (FIRST/SECOND/THIRD), which sits directly downstream.
//  Each button is synchronised, then debounced by a per-button FSM with a stability counter.
//  Restart becomes a single-cycle pulse; pause becomes a level, either toggled or followed.
// PARAMETERS
//  DB_CYCLES    4  consecutive stable synced samples needed to accept a change; must be >= 2
//  PAUSE_TOGGLE 1  1: each accepted pause press toggles pause; 0: pause = debounced level
//  CNT_W        $clog2(DB_CYCLES+1)  stability counter width (derived; do not override)
// PORTS
//  clk          in   1  rising-edge clock
//  rst          in   1  asynchronous, active-LOW reset (0 = reset)
//  pause_raw    in   1  raw pause button, asynchronous, may bounce
//  restart_raw  in   1  raw restart button, asynchronous, may bounce
//  pause        out  1  registered pause control to the sequencer
//  restart      out  1  registered restart control to the sequencer, 1-cycle pulse
//  pause_db     out  1  debounced pause button level (debug)
//  restart_db   out  1  debounced restart button level (debug)
// BEHAVIOUR
//  Reset (rst=0, async): all sync flops, counters, and outputs go to 0; both FSMs go to RELEASED.
//  Sync: a 2-flop synchroniser per input. s2 is the sample seen by the FSM.
//  Per-button FSM, one instance per button, states RELEASED/PRESS_WAIT/PRESSED/RELEASE_WAIT:
//   RELEASED:     s2=1 -> PRESS_WAIT, cnt=1; else stay.
//   PRESS_WAIT:   s2=0 -> RELEASED, cnt=0.
//                 s2=1 & cnt==DB_CYCLES-1 -> PRESSED, cnt=0, press event.
//                 s2=1 otherwise -> cnt+1.
//   PRESSED:      s2=0 -> RELEASE_WAIT, cnt=1; else stay.
//   RELEASE_WAIT: s2=1 -> PRESSED, cnt=0.
//                 s2=0 & cnt==DB_CYCLES-1 -> RELEASED, cnt=0.
//                 s2=0 otherwise -> cnt+1.
//  The counter never exceeds DB_CYCLES-1 and never wraps.
//  The debounced level (x_db) is 1 in PRESSED and RELEASE_WAIT.
//  Latency: raw first sampled high at edge k and held high. The press event is
//   registered at edge k+DB_CYCLES+1, so restart/pause/pause_db update after that edge.
//  restart: 1 for exactly the one cycle after a restart press event, else 0.
//   A held button never re-pulses until a debounced release and a new press occur.
//  pause, PAUSE_TOGGLE=1: toggles on each pause press event.
//  pause, PAUSE_TOGGLE=0: pause = pause_db.
//  A restart press event forces pause to 0 in either mode. In mode 0 this clear is
//   cycle-only; pause re-follows pause_db from the next edge.
//  Restart and pause press events on the same edge: restart pulses and pause=0
//   (restart wins).
//  Reset mid-operation: all progress is discarded. A button still held when rst
//   rises is treated as a new press and takes the full DB_CYCLES+2 edge latency.
// TESTING (DB_CYCLES=4 unless noted)
//  1 restart_raw 0->1 sampled at edge 10, held 20 cycles -> restart=1 only after
//    edge 15 for one cycle; restart_db=1 from edge 15.
//  2 restart_raw glitches 1,1,0,1,1,1,0 then holds 1 -> no pulse during the
//    glitches; exactly one pulse, 4 stable s2 samples after the final 0.
//  3 two clean press/release cycles on pause_raw (PAUSE_TOGGLE=1) -> pause goes
//    0->1 after the first press, 1->0 after the second; releases cause no change.
//  4 pause=1, both raw inputs rise on the same edge -> on the accept edge
//    restart=1 for one cycle and pause=0.
//  5 pause_raw held; rst=0 after 2 PRESS_WAIT cycles, released at edge 30 ->
//    all outputs stay 0 through edge 35; pause=1 after edge 36.
//  6 PAUSE_TOGGLE=0, press held 10 cycles then released -> pause tracks pause_db;
//    it falls 4 stable-low samples after the release reaches s2.

Source files
------------

// File: rtl/ctrl_debounce.sv
// ctrl_debounce: turns two raw, bouncing push-buttons into the pause/restart
// controls of the downstream FIRST/SECOND/THIRD sequencer.
//
// ctrl_debounce_btn (per button): 2-flop synchroniser + 4-state debounce FSM
//   clk        in  rising-edge clock
//   rst        in  asynchronous active-low reset
//   raw        in  raw button input (asynchronous, may bounce)
//   db_next    out debounced level the FSM takes at the next edge
//   press_evt  out high in the cycle whose edge accepts a press
//
// ctrl_debounce (top)
//   clk         in  rising-edge clock
//   rst         in  asynchronous active-low reset
//   pause_raw   in  raw pause button
//   restart_raw in  raw restart button
//   pause       out registered pause control (toggled or followed)
//   restart     out registered one-cycle restart pulse
//   pause_db    out debounced pause level (debug)
//   restart_db  out debounced restart level (debug)

module ctrl_debounce_btn #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db_next,
  output logic press_evt
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  state_t           state, nstate;
  logic [CNT_W-1:0] cnt, ncnt;
  logic             s1, s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    unique case (state)
      RELEASED: begin
        if (s2) begin
          nstate = PRESS_WAIT;
          ncnt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          nstate = RELEASED;
          ncnt   = '0;
        end else if (cnt == CNT_LAST) begin
          nstate = PRESSED;
          ncnt   = '0;
        end else begin
          ncnt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s2) begin
          nstate = RELEASE_WAIT;
          ncnt   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          nstate = PRESSED;
          ncnt   = '0;
        end else if (cnt == CNT_LAST) begin
          nstate = RELEASED;
          ncnt   = '0;
        end else begin
          ncnt = cnt + CNT_ONE;
        end
      end
      default: begin
        nstate = RELEASED;
        ncnt   = '0;
      end
    endcase
  end

  // Both outputs look at the transition being taken, so the top can register
  // them on the same edge the FSM accepts the change.
  always_comb begin
    db_next   = (nstate == PRESSED) || (nstate == RELEASE_WAIT);
    press_evt = (state == PRESS_WAIT) && s2 && (cnt == CNT_LAST);
  end

endmodule

module ctrl_debounce #(
  parameter int DB_CYCLES    = 4,
  parameter bit PAUSE_TOGGLE = 1'b1,
  parameter int CNT_W        = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic pause_raw,
  input  logic restart_raw,
  output logic pause,
  output logic restart,
  output logic pause_db,
  output logic restart_db
);

  logic pause_db_next, pause_evt;
  logic restart_db_next, restart_evt;

  ctrl_debounce_btn #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_pause_btn (
    .clk      (clk),
    .rst      (rst),
    .raw      (pause_raw),
    .db_next  (pause_db_next),
    .press_evt(pause_evt)
  );

  ctrl_debounce_btn #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_restart_btn (
    .clk      (clk),
    .rst      (rst),
    .raw      (restart_raw),
    .db_next  (restart_db_next),
    .press_evt(restart_evt)
  );

  // The debounced levels are re-registered here rather than decoded from FSM
  // state; timing is identical and every FSM output stays in use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause      <= 1'b0;
      restart    <= 1'b0;
      pause_db   <= 1'b0;
      restart_db <= 1'b0;
    end else begin
      restart    <= restart_evt;
      pause_db   <= pause_db_next;
      restart_db <= restart_db_next;
      // Restart wins over a simultaneous pause press and, in follow mode,
      // clears pause for one cycle only.
      if (restart_evt) begin
        pause <= 1'b0;
      end else if (PAUSE_TOGGLE) begin
        if (pause_evt) pause <= ~pause;
      end else begin
        pause <= pause_db_next;
      end
    end
  end

endmodule
